// File: rtl/cond_pkg.sv
// Shared condition-code encodings, flag bit positions and strobe payload for the
// condition logic and its reusable condition checker.
package cond_pkg;

  localparam int unsigned COND_W  = 4;
  localparam int unsigned FLAGS_W = 4;
  localparam int unsigned FLAGW_W = 2;

  // Bit indices into the {N,Z,C,V} flag vector
  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  // flag_w bit selecting which flag pair gets loaded
  localparam int unsigned FW_NZ = 1;
  localparam int unsigned FW_CV = 0;

  localparam logic [COND_W-1:0] COND_EQ = 4'b0000;
  localparam logic [COND_W-1:0] COND_NE = 4'b0001;
  localparam logic [COND_W-1:0] COND_CS = 4'b0010;
  localparam logic [COND_W-1:0] COND_CC = 4'b0011;
  localparam logic [COND_W-1:0] COND_MI = 4'b0100;
  localparam logic [COND_W-1:0] COND_PL = 4'b0101;
  localparam logic [COND_W-1:0] COND_VS = 4'b0110;
  localparam logic [COND_W-1:0] COND_VC = 4'b0111;
  localparam logic [COND_W-1:0] COND_HI = 4'b1000;
  localparam logic [COND_W-1:0] COND_LS = 4'b1001;
  localparam logic [COND_W-1:0] COND_GE = 4'b1010;
  localparam logic [COND_W-1:0] COND_LT = 4'b1011;
  localparam logic [COND_W-1:0] COND_GT = 4'b1100;
  localparam logic [COND_W-1:0] COND_LE = 4'b1101;
  localparam logic [COND_W-1:0] COND_AL = 4'b1110;
  localparam logic [COND_W-1:0] COND_NV = 4'b1111;

  typedef struct packed {
    logic pc_src;
    logic reg_write;
    logic mem_write;
  } strobe_t;

endpackage

// File: rtl/cond_check.sv
// Combinational evaluation of a 4-bit condition field against {N,Z,C,V}.
module cond_check
  import cond_pkg::*;
(
  input  logic [COND_W-1:0]  cond,
  input  logic [FLAGS_W-1:0] flags,
  output logic               cond_ex
);

  logic n;
  logic z;
  logic c;
  logic v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    cond_ex = 1'b0;
    unique case (cond)
      COND_EQ: cond_ex = z;
      COND_NE: cond_ex = ~z;
      COND_CS: cond_ex = c;
      COND_CC: cond_ex = ~c;
      COND_MI: cond_ex = n;
      COND_PL: cond_ex = ~n;
      COND_VS: cond_ex = v;
      COND_VC: cond_ex = ~v;
      COND_HI: cond_ex = c & ~z;
      COND_LS: cond_ex = ~c | z;
      COND_GE: cond_ex = (n == v);
      COND_LT: cond_ex = (n != v);
      COND_GT: cond_ex = ~z & (n == v);
      COND_LE: cond_ex = z | (n != v);
      COND_AL: cond_ex = 1'b1;
      COND_NV: cond_ex = 1'b0;
      default: cond_ex = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_logic.sv
// Architectural flag register plus condition gating of the decoder's write/branch
// strobes; strobes are combinational or one-cycle registered depending on REG_OUT.
module cond_logic
  import cond_pkg::*;
#(
  parameter logic [FLAGS_W-1:0] FLAGS_RESET = 4'b0000,
  parameter bit                 REG_OUT     = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [COND_W-1:0]  cond,
  input  logic [FLAGS_W-1:0] alu_flags,
  input  logic [FLAGW_W-1:0] flag_w,
  input  logic               pcs,
  input  logic               reg_w,
  input  logic               mem_w,
  input  logic               no_write,
  input  logic               in_valid,
  input  logic               stall,
  input  logic               flush,
  output logic               pc_src,
  output logic               reg_write,
  output logic               mem_write,
  output logic               cond_ex,
  output logic [FLAGS_W-1:0] flags
);

  logic [FLAGS_W-1:0] flags_q;
  logic               go_c;
  strobe_t            strobe_c;

  // Condition is judged against the committed flags only; no alu_flags bypass
  cond_check u_cond_check (
    .cond    (cond),
    .flags   (flags_q),
    .cond_ex (cond_ex)
  );

  assign go_c = in_valid & cond_ex & ~flush;

  always_comb begin
    strobe_c           = '0;
    strobe_c.pc_src    = go_c & pcs;
    strobe_c.reg_write = go_c & reg_w & ~no_write;
    strobe_c.mem_write = go_c & mem_w;
  end

  // N,Z and C,V pairs load independently
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_q <= FLAGS_RESET;
    end else if (go_c && !stall) begin
      if (flag_w[FW_NZ]) begin
        flags_q[FLAG_N:FLAG_Z] <= alu_flags[FLAG_N:FLAG_Z];
      end
      if (flag_w[FW_CV]) begin
        flags_q[FLAG_C:FLAG_V] <= alu_flags[FLAG_C:FLAG_V];
      end
    end
  end

  assign flags = flags_q;

  if (REG_OUT) begin : g_reg_out
    strobe_t strobe_q;

    // Flush overrides stall; strobe_c is already zero under flush
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        strobe_q <= '0;
      end else if (flush || !stall) begin
        strobe_q <= strobe_c;
      end
    end

    assign pc_src    = strobe_q.pc_src;
    assign reg_write = strobe_q.reg_write;
    assign mem_write = strobe_q.mem_write;
  end else begin : g_comb_out
    assign pc_src    = strobe_c.pc_src;
    assign reg_write = strobe_c.reg_write;
    assign mem_write = strobe_c.mem_write;
  end

endmodule
